// File: rtl/hls_dma_pkg.sv
// rtl/hls_dma_pkg.sv - shared DMA FSM states, AXI response code and 4 KB page helpers
package hls_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } dma_state_t;

    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam int         BOUNDARY_4K       = 4096;
    localparam int         BURST_MAX_DEFAULT = 16;

    // Words left before the next 4 KB page boundary, given the word offset inside the page
    function automatic logic [10:0] words_to_4k(input logic [9:0] word_off);
        return 11'(BOUNDARY_4K / 4) - {1'b0, word_off};
    endfunction

endpackage

// File: rtl/hls_rdma_fifo.sv
// rtl/hls_rdma_fifo.sv - synchronous FIFO with occupancy count; a word is readable the cycle after it is written
module hls_rdma_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy update; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hls_rdma.sv
// rtl/hls_rdma.sv - AXI4 read DMA to AXI4-Stream; define RDMA_RRESP_CHK_EN for the sticky RRESP error flag
import hls_dma_pkg::*;

module hls_rdma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_MAX  = BURST_MAX_DEFAULT,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = LEN_WIDTH + 1;

    dma_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  sbeat_q;
    logic [8:0]            burst_q;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         free_slots;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic                  r_fire;
    logic                  s_fire;
    logic [BW-1:0]         remaining;
    logic [BW-1:0]         to_4k;
    logic [BW-1:0]         burst;
    logic                  credit_ok;
    logic                  unused_ok;

    assign unused_ok     = ^cfg_base[1:0];
    assign r_fire        = m_axi_rvalid && m_axi_rready;
    assign m_axis_tvalid = !fifo_empty;
    assign s_fire        = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && (sbeat_q == len_q - LEN_WIDTH'(1));
    assign free_slots    = CW'(FIFO_DEPTH) - fifo_count;

    // Next burst length: capped by BURST_MAX, words still to request and the 4 KB page end.
    // Only one AR is ever outstanding and ADDR is entered after rlast, so the whole free
    // space is available credit when a new burst is considered.
    always_comb begin
        remaining = BW'(len_q - issued_q);
        to_4k     = BW'(words_to_4k(addr_q[11:2]));
        burst     = BW'(BURST_MAX);
        if (remaining < burst) burst = remaining;
        if (to_4k < burst)     burst = to_4k;
        credit_ok = (BW'(free_slots) >= burst);
    end

    hls_rdma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (r_fire),
        .push_data (m_axi_rdata),
        .pop       (s_fire),
        .pop_data  (m_axis_tdata),
        .empty     (fifo_empty),
        .full      (fifo_full_unused),
        .count     (fifo_count)
    );

    // Control FSM: latches the job, issues one burst at a time, then waits for the stream to drain
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= ST_IDLE;
            ap_idle       <= 1'b1;
            ap_ready      <= 1'b0;
            ap_done       <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_rready  <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            sbeat_q       <= '0;
            burst_q       <= '0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            if (s_fire) sbeat_q <= sbeat_q + LEN_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        addr_q   <= {cfg_base[ADDR_WIDTH-1:2], 2'b00};
                        len_q    <= cfg_len;
                        issued_q <= '0;
                        sbeat_q  <= '0;
                        ap_ready <= 1'b1;
                        ap_idle  <= 1'b0;
                        if (cfg_len == '0) begin
                            ap_done <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!m_axi_arvalid) begin
                        if (credit_ok) begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= addr_q;
                            m_axi_arlen   <= 8'(burst - BW'(1));
                            burst_q       <= 9'(burst);
                        end
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        addr_q        <= addr_q + (ADDR_WIDTH'(burst_q) << 2);
                        issued_q      <= issued_q + LEN_WIDTH'(burst_q);
                        m_axi_rready  <= 1'b1;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire && m_axi_rlast) begin
                        m_axi_rready <= 1'b0;
                        state        <= (issued_q < len_q) ? ST_ADDR : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (s_fire && m_axis_tlast) begin
                        ap_done <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ap_idle <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ap_idle <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RDMA_RRESP_CHK_EN
    // Sticky error on any non-OKAY read response; cleared when the next job is accepted
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err <= 1'b0;
        end else if (state == ST_IDLE && ap_start) begin
            err <= 1'b0;
        end else if (r_fire && m_axi_rresp != AXI_RESP_OKAY) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_hls_rdma.sv
// tb/tb_hls_rdma.sv - self-checking bench for hls_rdma with a randomized AXI slave and stream sink
module tb_hls_rdma;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] cfg_base;
    logic [15:0] cfg_len;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        err;

    hls_rdma dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err           (err)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } ar_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] salt;
    ar_t         ar_log[$];
    ar_t         exp_ar[$];
    ar_t         rq[$];
    logic [32:0] got[$];
    logic [32:0] exp_data[$];
    int          rbeat;
    int          r_total;
    int          done_cnt;
    int          ready_cnt;
    int          rstall;
    int          ar_unstable;
    int          tready_mode;
    int          bad_beat;
    logic        ar_wait;
    logic [31:0] ar_addr_hold;
    logic [7:0]  ar_len_hold;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Reference: split the job into page-safe bursts and list the words in address order
    function automatic void model(input logic [31:0] base, input int len);
        logic [31:0] a;
        int          rem;
        int          b;
        int          to4k;
        a   = {base[31:2], 2'b00};
        rem = len;
        exp_ar.delete();
        exp_data.delete();
        for (int i = 0; i < len; i++)
            exp_data.push_back({(i == len - 1), mem_word(a + 32'(4 * i))});
        while (rem > 0) begin
            to4k = (4096 - int'(a[11:0])) / 4;
            b = 16;
            if (rem < b)  b = rem;
            if (to4k < b) b = to4k;
            exp_ar.push_back('{a, b});
            a   = a + 32'(4 * b);
            rem = rem - b;
        end
    endfunction

    function automatic int ar_diff();
        int n;
        n = (ar_log.size() > exp_ar.size()) ? ar_log.size() - exp_ar.size() : exp_ar.size() - ar_log.size();
        for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++)
            if (ar_log[i].addr !== exp_ar[i].addr || ar_log[i].len != exp_ar[i].len) n++;
        return n;
    endfunction

    function automatic int data_diff();
        int n;
        n = (got.size() > exp_data.size()) ? got.size() - exp_data.size() : exp_data.size() - got.size();
        for (int i = 0; i < got.size() && i < exp_data.size(); i++)
            if (got[i] !== exp_data[i]) n++;
        return n;
    endfunction

    function automatic void clear_log();
        ar_log.delete();
        rq.delete();
        got.delete();
        rbeat       = 0;
        r_total     = 0;
        done_cnt    = 0;
        ready_cnt   = 0;
        rstall      = 0;
        ar_unstable = 0;
        ar_wait     = 1'b0;
    endfunction

    // One cycle of the AXI slave and stream sink, evaluated on the falling edge
    task automatic step();
        @(negedge ap_clk);
        if (ar_wait && (!m_axi_arvalid || m_axi_araddr !== ar_addr_hold || m_axi_arlen !== ar_len_hold))
            ar_unstable++;
        if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = mem_word(rq[0].addr + 32'(4 * rbeat));
            m_axi_rlast  = (rbeat == rq[0].len - 1);
            m_axi_rresp  = (r_total == bad_beat) ? 2'b10 : 2'b00;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
        end
        if (m_axi_rvalid && !m_axi_rready) rstall++;
        if (m_axi_rvalid && m_axi_rready) begin
            r_total++;
            rbeat++;
            if (rbeat == rq[0].len) begin
                void'(rq.pop_front());
                rbeat = 0;
            end
        end
        m_axi_arready = ($urandom_range(0, 2) != 0);
        if (m_axi_arvalid && m_axi_arready) begin
            ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen) + 1});
            rq.push_back('{m_axi_araddr, int'(m_axi_arlen) + 1});
            ar_wait = 1'b0;
        end else begin
            ar_wait      = m_axi_arvalid;
            ar_addr_hold = m_axi_araddr;
            ar_len_hold  = m_axi_arlen;
        end
        m_axis_tready = (tready_mode == 2) ? 1'($urandom_range(0, 1)) : tready_mode[0];
        if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
        if (ap_done)  done_cnt++;
        if (ap_ready) ready_cnt++;
    endtask

    task automatic start(input logic [31:0] base, input int len);
        cfg_base = base;
        cfg_len  = 16'(len);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        repeat (2) step();
    endtask

    task automatic test_reset();
        checks++; if (ap_idle !== 1'b1)       begin errors++; $display("FAIL reset_idle: got %b want 1", ap_idle); end
        checks++; if (ap_done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", ap_done); end
        checks++; if (ap_ready !== 1'b0)      begin errors++; $display("FAIL reset_ready: got %b want 0", ap_ready); end
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
        checks++; if (m_axi_rready !== 1'b0)  begin errors++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (err !== 1'b0)           begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        ap_rst = 1'b0;
        step();
    endtask

    task automatic test_single_burst();
        clear_log();
        tready_mode = 1;
        model(32'h0000_1000, 16);
        start(32'h0000_1000, 16);
        run(1000);
        checks++; if (ar_log.size() != 1 || ar_log[0].addr !== 32'h1000 || ar_log[0].len != 16)
            begin errors++; $display("FAIL single_ar: got %0d bursts, first @%h len %0d; want 1 @1000 len 16", ar_log.size(), (ar_log.size() > 0) ? ar_log[0].addr : 32'h0, (ar_log.size() > 0) ? ar_log[0].len : 0); end
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL single_stream: %0d bad beats of %0d", data_diff(), got.size()); end
        checks++; if (done_cnt != 1)   begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
        checks++; if (ready_cnt != 1)  begin errors++; $display("FAIL single_ready: got %0d pulses want 1", ready_cnt); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", ap_idle); end
    endtask

    task automatic test_4k_split();
        clear_log();
        tready_mode = 2;
        model(32'h0000_0FF8, 8);
        start(32'h0000_0FF8, 8);
        run(1000);
        checks++; if (ar_log.size() != 2 || ar_log[0].addr !== 32'h0FF8 || ar_log[0].len != 2 || ar_log[1].addr !== 32'h1000 || ar_log[1].len != 6)
            begin errors++; $display("FAIL split_ar: got %0d bursts, ar_diff=%0d; want @0FF8x2 then @1000x6", ar_log.size(), ar_diff()); end
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL split_stream: %0d bad beats", data_diff()); end
        checks++; if (done_cnt != 1)   begin errors++; $display("FAIL split_done: got %0d want 1", done_cnt); end
        checks++; if (ar_unstable != 0) begin errors++; $display("FAIL split_ar_stable: %0d changes while waiting", ar_unstable); end
    endtask

    task automatic test_backpressure();
        clear_log();
        tready_mode = 0;
        model(32'h0000_2000, 40);
        start(32'h0000_2000, 40);
        repeat (100) step();
        checks++; if (r_total > 32 || r_total < 16) begin errors++; $display("FAIL bp_fetched: got %0d words want 16..32", r_total); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL bp_no_stream: got %0d beats want 0", got.size()); end
        tready_mode = 1;
        run(2000);
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL bp_stream: %0d bad beats of %0d", data_diff(), got.size()); end
        checks++; if (ar_diff() != 0)   begin errors++; $display("FAIL bp_ar: %0d burst mismatches", ar_diff()); end
        checks++; if (rstall != 0)      begin errors++; $display("FAIL bp_r_stall: got %0d stalled beats want 0", rstall); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        clear_log();
        tready_mode = 1;
        start(32'h0000_3000, 0);
        checks++; if (ap_ready !== 1'b1 || ap_done !== 1'b1)
            begin errors++; $display("FAIL zero_pulses: got ready=%b done=%b want 1 1", ap_ready, ap_done); end
        repeat (4) step();
        checks++; if (ar_log.size() != 0) begin errors++; $display("FAIL zero_ar: got %0d bursts want 0", ar_log.size()); end
        checks++; if (got.size() != 0)    begin errors++; $display("FAIL zero_stream: got %0d beats want 0", got.size()); end
        checks++; if (done_cnt != 1)      begin errors++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
        checks++; if (ap_idle !== 1'b1)   begin errors++; $display("FAIL zero_idle: got %b want 1", ap_idle); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        tready_mode = 2;
        start(32'h0000_4000, 32);
        for (int i = 0; i < 400 && r_total < 3; i++) step();
        checks++; if (r_total < 3) begin errors++; $display("FAIL mid_reached: got %0d beats want >=3", r_total); end
        ap_rst       = 1'b1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        rq.delete();
        rbeat        = 0;
        ar_wait      = 1'b0;
        step();
        ap_rst = 1'b0;
        checks++; if (ap_idle !== 1'b1)       begin errors++; $display("FAIL mid_idle: got %b want 1", ap_idle); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL mid_arvalid: got %b want 0", m_axi_arvalid); end
        checks++; if (m_axi_rready !== 1'b0)  begin errors++; $display("FAIL mid_rready: got %b want 0", m_axi_rready); end
        step();
        clear_log();
        model(32'h0000_5010, 4);
        start(32'h0000_5010, 4);
        run(1000);
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL mid_restart_stream: %0d bad beats of %0d", data_diff(), got.size()); end
        checks++; if (ar_diff() != 0)   begin errors++; $display("FAIL mid_restart_ar: %0d burst mismatches", ar_diff()); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL mid_restart_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] base;
        int          len;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin
                base = 32'hFFFF_FFF0;
                len  = 8;
            end else if (it % 2 == 1) begin
                base = ($urandom & 32'hFFFF_F000) | (32'h1000 - 32'(4 * $urandom_range(1, 24))) | 32'($urandom_range(0, 3));
                len  = $urandom_range(1, 70);
            end else begin
                base = $urandom;
                len  = $urandom_range(1, 70);
            end
            clear_log();
            tready_mode = 2;
            model(base, len);
            start(base, len);
            run(3000);
            checks++; if (ar_diff() != 0)   begin errors++; $display("FAIL rand%0d_ar: base %h len %0d, %0d burst mismatches", it, base, len, ar_diff()); end
            checks++; if (data_diff() != 0) begin errors++; $display("FAIL rand%0d_stream: base %h len %0d, %0d bad beats", it, base, len, data_diff()); end
            checks++; if (done_cnt != 1)    begin errors++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
            checks++; if (rstall != 0 || ar_unstable != 0)
                begin errors++; $display("FAIL rand%0d_handshake: r stalls %0d, ar changes %0d, want 0 0", it, rstall, ar_unstable); end
        end
    endtask

    task automatic test_rresp();
        logic seen;
        clear_log();
        tready_mode = 1;
        bad_beat    = 3;
        seen        = 1'b0;
        model(32'h0000_6000, 8);
        start(32'h0000_6000, 8);
        for (int i = 0; i < 1000 && done_cnt == 0; i++) begin
            step();
            if (!seen && r_total == 4) begin
                seen = 1'b1;
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rresp_before: got %b want 0", err); end
                step();
`ifdef RDMA_RRESP_CHK_EN
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL rresp_set: got %b want 1", err); end
`else
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rresp_tied: got %b want 0", err); end
`endif
            end
        end
        repeat (2) step();
        bad_beat = -1;
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL rresp_stream: %0d bad beats", data_diff()); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL rresp_done: got %0d want 1", done_cnt); end
        clear_log();
        model(32'h0000_7000, 2);
        start(32'h0000_7000, 2);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rresp_clear: got %b want 0", err); end
        run(1000);
        checks++; if (data_diff() != 0) begin errors++; $display("FAIL rresp_next_stream: %0d bad beats", data_diff()); end
    endtask

    initial begin
        salt          = $urandom;
        ap_rst        = 1'b1;
        ap_start      = 1'b0;
        cfg_base      = '0;
        cfg_len       = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axis_tready = 1'b0;
        tready_mode   = 1;
        bad_beat      = -1;
        ar_addr_hold  = '0;
        ar_len_hold   = '0;
        clear_log();
        repeat (3) @(negedge ap_clk);
        test_reset();
        test_single_burst();
        test_4k_split();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        test_rresp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
